// File: rtl/vector_pkg.sv
// Shared types and defaults for the vector display blocks.
package vector_pkg;

  localparam int VLG_CH_WIDTH = 8;
  localparam int VLG_STEP_DIV = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } vlg_state_t;

endpackage

// File: rtl/step_tick_gen.sv
// Clock-enable tick generator: one tick every STEP_DIV enabled cycles.
// Tick is combinational from the counter; enable=0 freezes the count, clear restarts it.
module step_tick_gen #(
  parameter int STEP_DIV  = 100,
  parameter int DIV_WIDTH = $clog2(STEP_DIV + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  if (STEP_DIV < 1) begin : g_bad_div
    $error("step_tick_gen: STEP_DIV must be >= 1");
  end

  localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(STEP_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] INC  = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + INC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vector_line_gen.sv
// Bresenham line stepper for the X/Y DAC channels; one segment per valid/ready transfer.
// Position moves one pixel per step tick; seg_ready only in IDLE, so a segment is accepted every (steps+1)*STEP_DIV+2 cycles at best.
module vector_line_gen
  import vector_pkg::*;
#(
  parameter int CH_WIDTH  = VLG_CH_WIDTH,
  parameter int STEP_DIV  = VLG_STEP_DIV,
  parameter int DIV_WIDTH = $clog2(STEP_DIV + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                seg_valid,
  output logic                seg_ready,
  input  logic [CH_WIDTH-1:0] x0,
  input  logic [CH_WIDTH-1:0] y0,
  input  logic [CH_WIDTH-1:0] x1,
  input  logic [CH_WIDTH-1:0] y1,
  output logic [CH_WIDTH-1:0] x_ch,
  output logic [CH_WIDTH-1:0] y_ch,
  output logic                beam_on,
  output logic                busy,
  output logic                done
);

  localparam int EW = CH_WIDTH + 2;
  localparam logic [CH_WIDTH-1:0] ONE = CH_WIDTH'(1);

  vlg_state_t state_q, state_d;
  logic [CH_WIDTH-1:0] x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;
  logic [CH_WIDTH-1:0] dx_q, dx_d, dy_q, dy_d;   // dy_q holds |dy|
  logic sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [EW-1:0] err_q, err_d, err_acc, dx_a, dy_a;
  logic signed [EW:0]   e2, dx_c, dy_c;
  logic xfer, tick, at_end, step_x, step_y;

  step_tick_gen #(
    .STEP_DIV  (STEP_DIV),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (xfer),
    .tick   (tick)
  );

  assign seg_ready = (state_q == IDLE);
  assign xfer      = seg_valid && seg_ready;
  assign at_end    = (x_q == xe_q) && (y_q == ye_q);

  // Two guard bits keep err and 2*err exact for a full-scale 0 -> 2^W-1 run.
  assign dx_a   = $signed({2'b00, dx_q});
  assign dy_a   = -$signed({2'b00, dy_q});
  assign dx_c   = {dx_a[EW-1], dx_a};
  assign dy_c   = {dy_a[EW-1], dy_a};
  assign e2     = {err_q, 1'b0};
  assign step_x = (e2 >= dy_c);
  assign step_y = (e2 <= dx_c);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    err_d    = err_q;
    err_acc  = err_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          x_d      = x0;
          y_d      = y0;
          xe_d     = x1;
          ye_d     = y1;
          dx_d     = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
          dy_d     = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
          sx_neg_d = (x1 < x0);
          sy_neg_d = (y1 < y0);
          err_d    = $signed({2'b00, dx_d}) - $signed({2'b00, dy_d});
          state_d  = DRAW;
        end
      end
      DRAW: begin
        if (tick) begin
          if (at_end) begin
            state_d = DONE;
          end else begin
            if (step_x) begin
              err_acc = err_acc + dy_a;
              x_d     = sx_neg_q ? (x_q - ONE) : (x_q + ONE);
            end
            if (step_y) begin
              err_acc = err_acc + dx_a;
              y_d     = sy_neg_q ? (y_q - ONE) : (y_q + ONE);
            end
            err_d = err_acc;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      err_q    <= err_d;
    end
  end

  assign x_ch    = x_q;
  assign y_ch    = y_q;
  assign beam_on = (state_q == DRAW);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_vector_line_gen.sv
// Directed bench: three instances with STEP_DIV 4, 1 and 2 sharing clk/rst/enable.
module tb_vector_line_gen;

  localparam int STEEP_X[8] = '{5, 5, 4, 4, 4, 4, 3, 3};
  localparam int STEEP_Y[8] = '{9, 8, 7, 6, 5, 4, 3, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] seg_valid, seg_ready, beam_on, busy, done;
  logic [7:0] x0 [3];
  logic [7:0] y0 [3];
  logic [7:0] x1 [3];
  logic [7:0] y1 [3];
  logic [7:0] x_ch [3];
  logic [7:0] y_ch [3];

  int n_checks = 0;
  int n_err    = 0;
  int beam_cnt, done_cnt, ex;

  always #5 clk = ~clk;

  vector_line_gen #(.CH_WIDTH(8), .STEP_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .enable(enable),
    .seg_valid(seg_valid[0]), .seg_ready(seg_ready[0]),
    .x0(x0[0]), .y0(y0[0]), .x1(x1[0]), .y1(y1[0]),
    .x_ch(x_ch[0]), .y_ch(y_ch[0]),
    .beam_on(beam_on[0]), .busy(busy[0]), .done(done[0])
  );

  vector_line_gen #(.CH_WIDTH(8), .STEP_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .enable(enable),
    .seg_valid(seg_valid[1]), .seg_ready(seg_ready[1]),
    .x0(x0[1]), .y0(y0[1]), .x1(x1[1]), .y1(y1[1]),
    .x_ch(x_ch[1]), .y_ch(y_ch[1]),
    .beam_on(beam_on[1]), .busy(busy[1]), .done(done[1])
  );

  vector_line_gen #(.CH_WIDTH(8), .STEP_DIV(2)) u_div2 (
    .clk(clk), .rst(rst), .enable(enable),
    .seg_valid(seg_valid[2]), .seg_ready(seg_ready[2]),
    .x0(x0[2]), .y0(y0[2]), .x1(x1[2]), .y1(y1[2]),
    .x_ch(x_ch[2]), .y_ch(y_ch[2]),
    .beam_on(beam_on[2]), .busy(busy[2]), .done(done[2])
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_seg(input int i, input int a, input int b, input int c, input int d);
    x0[i] = 8'(a);
    y0[i] = 8'(b);
    x1[i] = 8'(c);
    y1[i] = 8'(d);
  endtask

  // Present a segment, let it transfer, return at the first DRAW cycle.
  task automatic launch(input int i, input int a, input int b, input int c, input int d);
    set_seg(i, a, b, c, d);
    seg_valid[i] = 1'b1;
    step();
    seg_valid[i] = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b1;
    seg_valid = '0;
    for (int i = 0; i < 3; i++) set_seg(i, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("rst_x", x_ch[i], 0);
      chk("rst_y", y_ch[i], 0);
      chk("rst_beam", beam_on[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_ready", seg_ready[i], 1);
    end

    // Horizontal (10,20)->(15,20), STEP_DIV=4
    launch(0, 10, 20, 15, 20);
    beam_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 26; k++) begin
      chk("h_x", x_ch[0], (k < 24) ? 10 + k / 4 : 15);
      chk("h_y", y_ch[0], 20);
      if (k == 24) chk("h_done_at_24", done[0], 1);
      if (k == 25) chk("h_ready_after", seg_ready[0], 1);
      beam_cnt += int'(beam_on[0]);
      done_cnt += int'(done[0]);
      step();
    end
    chk("h_beam_cycles", beam_cnt, 24);
    chk("h_done_pulses", done_cnt, 1);

    // Steep negative (5,9)->(3,2), STEP_DIV=1
    launch(1, 5, 9, 3, 2);
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        chk("s_x", x_ch[1], STEEP_X[k]);
        chk("s_y", y_ch[1], STEEP_Y[k]);
        chk("s_beam", beam_on[1], 1);
      end else begin
        chk("s_hold_x", x_ch[1], 3);
        chk("s_hold_y", y_ch[1], 2);
        chk(k == 8 ? "s_done" : "s_done_end", done[1], k == 8 ? 1 : 0);
      end
      step();
    end

    // Degenerate dot then full-scale diagonal, seg_valid held, STEP_DIV=2
    set_seg(2, 7, 7, 7, 7);
    seg_valid[2] = 1'b1;
    step();
    set_seg(2, 0, 0, 255, 255);
    beam_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 518; k++) begin
      if (k < 2) begin
        chk("d_dot_x", x_ch[2], 7);
        chk("d_dot_beam", beam_on[2], 1);
      end else if (k == 2) begin
        chk("d_dot_done", done[2], 1);
        chk("d_dot_hold", x_ch[2], 7);
      end else if (k == 3) begin
        chk("d_b2b_ready", seg_ready[2], 1);
      end else if (k < 516) begin
        ex = (k - 4) / 2;
        chk("g_diag_x", x_ch[2], ex);
        chk("g_diag_y", y_ch[2], ex);
      end else begin
        chk("g_diag_end_x", x_ch[2], 255);
        chk("g_diag_end_y", y_ch[2], 255);
        chk(k == 516 ? "g_diag_done" : "g_diag_idle", done[2], k == 516 ? 1 : 0);
      end
      beam_cnt += int'(beam_on[2]);
      done_cnt += int'(done[2]);
      if (k == 4) seg_valid[2] = 1'b0;
      step();
    end
    chk("d_beam_cycles", beam_cnt, 514);
    chk("d_done_pulses", done_cnt, 2);

    // Enable gating (0,0)->(5,0), STEP_DIV=2, 10 frozen cycles
    launch(2, 0, 0, 5, 0);
    beam_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      if (k < 5)       ex = k / 2;
      else if (k < 15) ex = 2;
      else if (k < 22) ex = (k - 10) / 2;
      else             ex = 5;
      chk("e_x", x_ch[2], ex);
      if (k == 9) chk("e_beam_frozen", beam_on[2], 1);
      if (k == 22) chk("e_done_at_22", done[2], 1);
      beam_cnt += int'(beam_on[2]);
      done_cnt += int'(done[2]);
      if (k == 4)  enable = 1'b0;
      if (k == 14) enable = 1'b1;
      step();
    end
    chk("e_beam_cycles", beam_cnt, 22);
    chk("e_done_pulses", done_cnt, 1);

    // Reset mid-segment (0,0)->(50,0), STEP_DIV=4
    launch(0, 0, 0, 50, 0);
    repeat (10) step();
    chk("r_pre_x", x_ch[0], 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_x", x_ch[0], 0);
    chk("r_beam", beam_on[0], 0);
    chk("r_busy", busy[0], 0);
    chk("r_done", done[0], 0);
    chk("r_ready", seg_ready[0], 1);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      done_cnt += int'(done[0]);
      step();
    end
    chk("r_no_done", done_cnt, 0);
    launch(0, 1, 1, 2, 1);
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) begin
        chk("r_new_x", x_ch[0], 1);
        chk("r_new_busy", busy[0], 1);
      end
      if (k == 8) begin
        chk("r_new_done", done[0], 1);
        chk("r_new_end_x", x_ch[0], 2);
      end
      done_cnt += int'(done[0]);
      step();
    end
    chk("r_new_done_pulses", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
